// File: rtl/c1_bus_slave.sv
// c1_bus_slave
// Cache-side terminal of the CPU<->L1 (C1) bus. Decodes the two-beat C1
// command/address phase, captures write data, hands one request per
// transaction to the cache core over a valid/ready port, then drives the C1
// response (WRITE32_RESP opcode plus read data) back onto the shared
// tri-state command/data lines.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-high
//   address    C1 address: tag+set on beat 1, offset in low bits on beat 2
//   data       C1 data bus (inout), driven only during read response beats
//   command    C1 command bus (inout), driven only in WAIT/RESP states
//   req_valid  request to cache core
//   req_ready  core accepts request
//   req_cmd    captured C1 opcode
//   req_addr   {tag_set, offset}
//   req_wdata  write data, 8/16-bit writes zero-extended
//   rsp_valid  core completion pulse
//   rsp_rdata  read data, valid with rsp_valid
module c1_bus_slave #(
    parameter int unsigned MEM_ADDR_SIZE     = 19,
    parameter int unsigned BUS_SIZE          = 16,
    parameter int unsigned CACHE_OFFSET_SIZE = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                    data,
    inout  wire  [2:0]                             command,
    output logic                                   req_valid,
    input  logic                                   req_ready,
    output logic [2:0]                             req_cmd,
    output logic [MEM_ADDR_SIZE-1:0]               req_addr,
    output logic [2*BUS_SIZE-1:0]                  req_wdata,
    input  logic                                   rsp_valid,
    input  logic [2*BUS_SIZE-1:0]                  rsp_rdata
);

    localparam logic [2:0] CmdNop     = 3'd0;
    localparam logic [2:0] CmdRead8   = 3'd1;
    localparam logic [2:0] CmdRead32  = 3'd3;
    localparam logic [2:0] CmdWrite8  = 3'd5;
    localparam logic [2:0] CmdWrite32 = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StAddr2,
        StTurn,
        StWait,
        StResp1,
        StResp2
    } state_e;

    state_e              state;
    logic                cmd_oe;
    logic [2:0]          cmd_out;
    logic                data_oe;
    logic [BUS_SIZE-1:0] data_out;
    logic [BUS_SIZE-1:0] rsp_hi;

    logic is_read;
    assign is_read = (req_cmd >= CmdRead8) && (req_cmd <= CmdRead32);

    assign command = cmd_oe  ? cmd_out  : 'z;
    assign data    = data_oe ? data_out : 'z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            req_valid <= 1'b0;
            req_cmd   <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            cmd_oe    <= 1'b0;
            cmd_out   <= CmdNop;
            data_oe   <= 1'b0;
            data_out  <= '0;
            rsp_hi    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    // A floating or unknown bus compares as not-nonzero and is ignored.
                    if (command != CmdNop) begin
                        req_cmd <= command;
                        req_addr[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE] <= address;
                        req_wdata[2*BUS_SIZE-1:BUS_SIZE] <= '0;
                        if (command == CmdWrite8) begin
                            req_wdata[BUS_SIZE-1:0] <= {{(BUS_SIZE-8){1'b0}}, data[7:0]};
                        end else begin
                            req_wdata[BUS_SIZE-1:0] <= data;
                        end
                        state <= StAddr2;
                    end
                end
                StAddr2: begin
                    req_addr[CACHE_OFFSET_SIZE-1:0] <= address[CACHE_OFFSET_SIZE-1:0];
                    if (req_cmd == CmdWrite32) begin
                        req_wdata[2*BUS_SIZE-1:BUS_SIZE] <= data;
                    end
                    state <= StTurn;
                end
                StTurn: begin
                    req_valid <= 1'b1;
                    cmd_oe    <= 1'b1;
                    cmd_out   <= CmdNop;
                    state     <= StWait;
                end
                StWait: begin
                    if (req_valid && req_ready) begin
                        req_valid <= 1'b0;
                    end
                    // Completion only counts once the request has been accepted.
                    if (!req_valid && rsp_valid) begin
                        rsp_hi  <= rsp_rdata[2*BUS_SIZE-1:BUS_SIZE];
                        cmd_out <= CmdWrite32;
                        data_oe <= is_read;
                        if (req_cmd == CmdRead8) begin
                            data_out <= {{(BUS_SIZE-8){1'b0}}, rsp_rdata[7:0]};
                        end else begin
                            data_out <= rsp_rdata[BUS_SIZE-1:0];
                        end
                        state <= StResp1;
                    end
                end
                StResp1: begin
                    if (req_cmd == CmdRead32) begin
                        data_out <= rsp_hi;
                        data_oe  <= 1'b1;
                        state    <= StResp2;
                    end else begin
                        cmd_oe  <= 1'b0;
                        data_oe <= 1'b0;
                        state   <= StIdle;
                    end
                end
                StResp2: begin
                    cmd_oe  <= 1'b0;
                    data_oe <= 1'b0;
                    state   <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
